// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter for N requestors with a registered one-hot grant and a per-holder burst limit.
// Optional macro RR_ARB_LOCK_EN adds a lock input that pins the grant on the current holder.
//
// state   | meaning
// S_IDLE  | no grant outstanding, gnt_valid=0
// S_GRANT | gnt holds one requestor, gnt_valid=1
module rr_arbiter_n #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id
`ifdef RR_ARB_LOCK_EN
  ,
  input  logic                 lock
`endif
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]    state, state_nxt;
  logic [N-1:0]  gnt_nxt;
  logic [IW-1:0] id_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [IW-1:0] sel;
  logic          found;
  logic          others;
  logic          keep;
  logic          lock_on;

`ifdef RR_ARB_LOCK_EN
  assign lock_on = lock;
`else
  assign lock_on = 1'b0;
`endif

  assign others = |(req & ~gnt);
  assign keep   = (state == S_GRANT) && req[gnt_id] &&
                  ((cnt < CNT_MAX) || !others || lock_on);

  // ptr already sits at holder+1, so the holder is naturally the last candidate.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        sel   = IW'((int'(ptr) + k) % N);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    id_nxt    = gnt_id;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    if (keep) begin
      cnt_nxt = (cnt < CNT_MAX) ? cnt + 1'b1 : cnt;
    end else if (found) begin
      state_nxt    = S_GRANT;
      gnt_nxt      = '0;
      gnt_nxt[sel] = 1'b1;
      id_nxt       = sel;
      cnt_nxt      = CW'(1);
      ptr_nxt      = IW'((int'(sel) + 1) % N);
    end else begin
      state_nxt = S_IDLE;
      gnt_nxt   = '0;
      id_nxt    = '0;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      gnt    <= '0;
      gnt_id <= '0;
      cnt    <= '0;
      ptr    <= '0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      gnt_id <= id_nxt;
      cnt    <= cnt_nxt;
      ptr    <= ptr_nxt;
    end
  end

  assign gnt_valid = (state == S_GRANT);

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed bench for rr_arbiter_n with N=4, HOLD_MAX=2.
// Lock scenario is compiled only when RR_ARB_LOCK_EN is defined.
module tb_rr_arbiter_n;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
`ifdef RR_ARB_LOCK_EN
  logic       lock;
`endif

  int total;
  int passed;

  rr_arbiter_n #(.N(4), .HOLD_MAX(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
`ifdef RR_ARB_LOCK_EN
    ,
    .lock      (lock)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if ($isunknown(req)) $display("FAIL req_known: req=%b required no X/Z", req);
      else passed++;
    end
  end

  task automatic do_reset(input logic [3:0] r);
    rst = 1'b1;
    req = r;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    #1;
    total++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0)
      $display("FAIL reset_outputs: gnt=%b valid=%b id=%0d required 0000/0/0", gnt, gnt_valid, gnt_id);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (gnt !== 4'b0001 || gnt_valid !== 1'b1 || gnt_id !== 2'd0)
      $display("FAIL reset_first_grant: gnt=%b valid=%b id=%0d required 0001/1/0", gnt, gnt_valid, gnt_id);
    else passed++;
  endtask

  task automatic test_full_contention();
    int ids [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    logic [3:0] exp_g;
    do_reset(4'b1111);
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      exp_g = 4'b0001 << ids[c];
      total++;
      if (gnt !== exp_g || gnt_id !== 2'(ids[c]) || gnt_valid !== 1'b1)
        $display("FAIL contention_c%0d: gnt=%b id=%0d valid=%b required %b/%0d/1", c, gnt, gnt_id, gnt_valid, exp_g, ids[c]);
      else passed++;
    end
  endtask

  task automatic test_two_sparse();
    int ids [6] = '{0, 0, 2, 2, 0, 0};
    logic [3:0] exp_g;
    do_reset(4'b0101);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      exp_g = 4'b0001 << ids[c];
      total++;
      if (gnt !== exp_g || gnt_id !== 2'(ids[c]))
        $display("FAIL sparse_c%0d: gnt=%b id=%0d required %b/%0d", c, gnt, gnt_id, exp_g, ids[c]);
      else passed++;
    end
  endtask

  task automatic test_sole_requestor();
    do_reset(4'b0100);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      total++;
      if (gnt !== 4'b0100 || gnt_id !== 2'd2 || gnt_valid !== 1'b1)
        $display("FAIL sole_c%0d: gnt=%b id=%0d valid=%b required 0100/2/1", c, gnt, gnt_id, gnt_valid);
      else passed++;
    end
  endtask

  task automatic test_release_handoff();
    do_reset(4'b0001);
    @(posedge clk); #1;
    total++;
    if (gnt !== 4'b0001) $display("FAIL handoff_start: gnt=%b required 0001", gnt);
    else passed++;
    req = 4'b0100;
    @(posedge clk); #1;
    total++;
    if (gnt !== 4'b0100 || gnt_valid !== 1'b1 || gnt_id !== 2'd2)
      $display("FAIL handoff_move: gnt=%b valid=%b id=%0d required 0100/1/2", gnt, gnt_valid, gnt_id);
    else passed++;
    req = 4'b1011;
    @(posedge clk); #1;
    total++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3)
      $display("FAIL handoff_ptr: gnt=%b id=%0d required 1000/3", gnt, gnt_id);
    else passed++;
  endtask

  // Continues from handoff: ptr is 0 after granting requestor 3.
  task automatic test_idle_wrap();
    req = 4'b0000;
    @(posedge clk); #1;
    total++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0)
      $display("FAIL idle_outputs: gnt=%b valid=%b id=%0d required 0000/0/0", gnt, gnt_valid, gnt_id);
    else passed++;
    req = 4'b1111;
    @(posedge clk); #1;
    total++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0)
      $display("FAIL idle_wrap_ptr: gnt=%b id=%0d required 0001/0", gnt, gnt_id);
    else passed++;
  endtask

  task automatic test_async_reset();
    do_reset(4'b1111);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (gnt !== 4'b0010) $display("FAIL async_pre: gnt=%b required 0010", gnt);
    else passed++;
    #1 rst = 1'b1;
    #1;
    total++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0)
      $display("FAIL async_clear: gnt=%b valid=%b id=%0d required 0000/0/0", gnt, gnt_valid, gnt_id);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0)
      $display("FAIL async_restart: gnt=%b id=%0d required 0001/0", gnt, gnt_id);
    else passed++;
  endtask

`ifdef RR_ARB_LOCK_EN
  task automatic test_lock();
    lock = 1'b1;
    do_reset(4'b1111);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      total++;
      if (gnt !== 4'b0001) $display("FAIL lock_hold_c%0d: gnt=%b required 0001", c, gnt);
      else passed++;
    end
    lock = 1'b0;
    @(posedge clk); #1;
    total++;
    if (gnt !== 4'b0010) $display("FAIL lock_release: gnt=%b required 0010", gnt);
    else passed++;
  endtask
`endif

  initial begin
    total  = 0;
    passed = 0;
    rst    = 1'b1;
    req    = 4'b0000;
`ifdef RR_ARB_LOCK_EN
    lock   = 1'b0;
`endif
    test_reset();
    test_full_contention();
    test_two_sparse();
    test_sole_requestor();
    test_release_handoff();
    test_idle_wrap();
    test_async_reset();
`ifdef RR_ARB_LOCK_EN
    test_lock();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/rr_arbiter_n.md
# rr_arbiter_n

Parametrised round-robin arbiter for N requestors with a registered one-hot grant and a per-grant burst limit. It grants a requestor and holds the grant while that requestor keeps requesting, up to HOLD_MAX consecutive cycles. After that it rotates to the next requestor. It replaces the fixed 4-port arbiter in shared-resource paths (bus, memory port, output mux) where port count and fairness window must be configurable.

## Interface
- N, 4, number of requestors; legal range N >= 2.
- HOLD_MAX, 4, maximum consecutive cycles one holder keeps the grant while any other requestor is waiting; legal range HOLD_MAX >= 1.
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N  request vector; bit i = requestor i. Level-sensitive.
- gnt  out  N  registered grant; one-hot or all-zero.
- gnt_valid  out  1  high when any gnt bit is high (registered).
- gnt_id  out  max(1,$clog2(N))  binary index of the granted requestor; 0 when gnt_valid=0.
- lock  in  1  present only with RR_ARB_LOCK_EN (see Configuration).

## Operation
- Internal state:
  - ptr: the priority start index, 0..N-1.
  - holder h: equal to gnt_id when gnt_valid=1.
  - cnt: width $clog2(HOLD_MAX+1), saturating at HOLD_MAX.
- Two states. IDLE means gnt_valid=0. GRANT means gnt_valid=1.
- Every posedge evaluates req in the order below; the first matching rule applies.
  1. In GRANT, with req[h]=1 and either cnt < HOLD_MAX or no other req bit set: keep h and set cnt <= min(cnt+1, HOLD_MAX).
  2. Otherwise, if any req bit is set (the holder's bit included): grant the first set bit searching upward from ptr with wrap N-1 -> 0. Set gnt <= onehot(i), gnt_id <= i, cnt <= 1, ptr <= (i+1) mod N.
  3. Otherwise: go to IDLE, gnt <= 0, gnt_id <= 0, cnt <= 0. ptr is unchanged.
- Forced rotation:
  - When rule 1 fails because the limit is reached, the search starts at ptr = h+1.
  - The holder is therefore the last candidate, so it wins again only if it is the sole requestor.
- Release: when the holder drops req, the grant moves at the same edge to the next requestor, with no dead cycle. If there is no other requestor, the arbiter goes to IDLE.
- Starvation bound: a continuously asserted request is granted within (N-1)*HOLD_MAX + 1 cycles.
- X on req is not permitted outside reset; the bench checks this.

## Timing
- Latency: req sampled at posedge k -> gnt valid after posedge k (visible in cycle k+1). Grant decisions are registered.
- gnt, gnt_valid and gnt_id change only at posedge or on rst assertion. They are glitch-free registered outputs.
- Reset values: gnt=0, gnt_valid=0, gnt_id=0, cnt=0, ptr=0. State is IDLE.
- rst assertion clears all outputs immediately, without waiting for clk, including mid-burst.
- The first grant occurs at the first posedge after rst deasserts, subject to req.
- Wrap-around: a grant to N-1 sets ptr=0.
- Simultaneous holder release and new request: the new request is eligible at that same edge.

## Configuration
- RR_ARB_LOCK_EN defined:
  - Adds input port lock.
  - While lock=1 and req[h]=1, the holder keeps the grant regardless of cnt, and cnt saturates at HOLD_MAX.
  - lock has no effect in IDLE or when req[h]=0.
  - When lock drops with cnt=HOLD_MAX and other requestors waiting, rotation occurs at the next edge.
- RR_ARB_LOCK_EN undefined: no lock port; behaviour is exactly as in Operation.

## Test plan
All scenarios use N=4, HOLD_MAX=2 unless stated.
- Reset: rst=1 with req=4'b1111 -> gnt=0, gnt_valid=0, gnt_id=0. First posedge after rst=0 -> gnt=4'b0001.
- Full contention: req=4'b1111 held 9 cycles -> gnt sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001.
- Sole requestor: req=4'b0100 held 10 cycles -> gnt=4'b0100 and gnt_id=2 every cycle, with no rotation or gap.
- Release handoff: holder 0 drops req0 while req2=1 -> next edge gnt=4'b0100, with no gnt_valid=0 cycle. ptr=3 afterwards, so with req=4'b1011 the next grant is 3.
- Lock (RR_ARB_LOCK_EN, N=4, HOLD_MAX=2): lock=1, req=4'b1111 -> gnt=0001 for 6 cycles. lock=0 -> gnt=0010 at the following edge.
- Async reset mid-burst: rst pulsed between edges during gnt=4'b0010 -> gnt=0 before the next posedge. After release, req=4'b1111 -> gnt=0001 (ptr reset to 0).
